// File: rtl/pipe5_cpu_fwd.sv
// Five-stage in-order CPU (IF/ID/EX/MEM/WB) with full EX forwarding, a one-cycle
// load-use interlock and two-cycle taken-BEQ flush; separate instruction and data memories.
module pipe5_cpu_fwd #(
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [$clog2(NREG)-1:0]       dbg_raddr,
  output logic [DATA_W-1:0]             dbg_rdata,
  output logic [DATA_W-1:0]             pc,
  output logic                          retire_valid,
  output logic [31:0]                   retire_count,
  output logic [31:0]                   stall_count
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int RAW = $clog2(NREG);
  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [31:0] NOP_IR = 32'h0000_0020;
  localparam logic [DATA_W-1:0] PC_MASK = DATA_W'(IMEM_DEPTH * 4 - 1);

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return DATA_W'(signed'(v));
  endfunction

  logic [31:0]       imem_q [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
  logic [DATA_W-1:0] regs_q [NREG];

  logic [DATA_W-1:0] pc_q, pc_d;
  logic              ifid_vld_q, ifid_vld_d;
  logic [31:0]       ifid_ir_q, ifid_ir_d;
  logic [DATA_W-1:0] ifid_pc_q, ifid_pc_d;
  logic              idex_vld_q, idex_vld_d;
  logic [31:0]       idex_ir_q, idex_ir_d;
  logic [DATA_W-1:0] idex_pc_q, idex_pc_d;
  logic [DATA_W-1:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic              exmem_vld_q, exmem_wr_q, exmem_lw_q, exmem_sw_q;
  logic [RAW-1:0]    exmem_dst_q;
  logic [DATA_W-1:0] exmem_alu_q, exmem_sd_q;
  logic              memwb_vld_q, memwb_wr_q;
  logic [RAW-1:0]    memwb_dst_q;
  logic [DATA_W-1:0] memwb_res_q;
  logic              retire_valid_q;
  logic [31:0]       retire_count_q, stall_count_q, stall_count_d;

  // IF: asynchronous fetch, so a same-cycle imem write is seen only next cycle
  logic [31:0] if_ir;
  assign if_ir = imem_q[pc_q[2 +: IAW]];

  always_ff @(posedge clock) begin
    if (imem_we) imem_q[imem_waddr] <= imem_wdata;
  end

  // ID: register read with write-through from WB
  logic [5:0]        id_op;
  logic [RAW-1:0]    id_rs, id_rt;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_a, id_b;
  assign id_op      = ifid_ir_q[31:26];
  assign id_rs      = ifid_ir_q[21 +: RAW];
  assign id_rt      = ifid_ir_q[16 +: RAW];
  assign id_uses_rt = (id_op == OP_R) || (id_op == OP_SW) || (id_op == OP_BEQ);
  assign id_a = (memwb_wr_q && memwb_dst_q == id_rs) ? memwb_res_q : regs_q[id_rs];
  assign id_b = (memwb_wr_q && memwb_dst_q == id_rt) ? memwb_res_q : regs_q[id_rt];

  // EX: decode, forwarding, ALU and branch resolution
  logic [5:0]               ex_op, ex_funct;
  logic [RAW-1:0]           ex_rs, ex_rt, ex_rd, ex_dst;
  logic signed [DATA_W-1:0] ex_imm;
  logic                     ex_add, ex_sub, ex_lw, ex_sw, ex_beq, ex_wr;
  logic [DATA_W-1:0]        ex_a, ex_b, ex_res, br_target;
  logic                     br_taken, ld_use;

  assign ex_op    = idex_ir_q[31:26];
  assign ex_rs    = idex_ir_q[21 +: RAW];
  assign ex_rt    = idex_ir_q[16 +: RAW];
  assign ex_rd    = idex_ir_q[11 +: RAW];
  assign ex_funct = idex_ir_q[5:0];
  assign ex_imm   = sext16(idex_ir_q[15:0]);
  assign ex_add   = (ex_op == OP_R) && (ex_funct == F_ADD);
  assign ex_sub   = (ex_op == OP_R) && (ex_funct == F_SUB);
  assign ex_lw    = (ex_op == OP_LW);
  assign ex_sw    = (ex_op == OP_SW);
  assign ex_beq   = (ex_op == OP_BEQ);
  assign ex_dst   = ex_lw ? ex_rt : ex_rd;
  assign ex_wr    = idex_vld_q && (((ex_add || ex_sub) && ex_rd != '0) ||
                                   (ex_lw && ex_rt != '0));

  // EX/MEM forwards only ALU results; a load there is caught by the interlock
  always_comb begin
    ex_a = idex_a_q;
    if (exmem_wr_q && !exmem_lw_q && exmem_dst_q == ex_rs) ex_a = exmem_alu_q;
    else if (memwb_wr_q && memwb_dst_q == ex_rs)           ex_a = memwb_res_q;
    ex_b = idex_b_q;
    if (exmem_wr_q && !exmem_lw_q && exmem_dst_q == ex_rt) ex_b = exmem_alu_q;
    else if (memwb_wr_q && memwb_dst_q == ex_rt)           ex_b = memwb_res_q;
  end

  assign ex_res    = ex_sub ? ex_a - ex_b : ex_add ? ex_a + ex_b : ex_a + $unsigned(ex_imm);
  assign br_taken  = idex_vld_q && ex_beq && (ex_a == ex_b);
  assign br_target = (idex_pc_q + DATA_W'(4) + $unsigned(ex_imm <<< 2)) & PC_MASK;
  assign ld_use    = idex_vld_q && ex_lw && (ex_rt != '0) && ifid_vld_q &&
                     ((id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));

  // Front-end next state: a taken branch wins over a load-use stall
  always_comb begin
    pc_d          = pc_q;
    ifid_vld_d    = ifid_vld_q;
    ifid_ir_d     = ifid_ir_q;
    ifid_pc_d     = ifid_pc_q;
    idex_vld_d    = ifid_vld_q;
    idex_ir_d     = ifid_ir_q;
    idex_pc_d     = ifid_pc_q;
    idex_a_d      = id_a;
    idex_b_d      = id_b;
    stall_count_d = stall_count_q;
    if (br_taken) begin
      pc_d       = br_target;
      ifid_vld_d = 1'b0;
      ifid_ir_d  = NOP_IR;
      idex_vld_d = 1'b0;
      idex_ir_d  = NOP_IR;
    end else if (ld_use) begin
      idex_vld_d    = 1'b0;
      idex_ir_d     = NOP_IR;
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      pc_d       = (pc_q + DATA_W'(4)) & PC_MASK;
      ifid_vld_d = 1'b1;
      ifid_ir_d  = if_ir;
      ifid_pc_d  = pc_q;
    end
  end

  // MEM: data memory access
  logic [DATA_W-1:0] mem_rdata, mem_res;
  assign mem_rdata = dmem_q[exmem_alu_q[2 +: DAW]];
  assign mem_res   = exmem_lw_q ? mem_rdata : exmem_alu_q;

  always_ff @(posedge clock) begin
    if (run && exmem_sw_q) dmem_q[exmem_alu_q[2 +: DAW]] <= exmem_sd_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= '0;
      ifid_vld_q     <= 1'b0;
      ifid_ir_q      <= NOP_IR;
      ifid_pc_q      <= '0;
      idex_vld_q     <= 1'b0;
      idex_ir_q      <= NOP_IR;
      idex_pc_q      <= '0;
      idex_a_q       <= '0;
      idex_b_q       <= '0;
      exmem_vld_q    <= 1'b0;
      exmem_wr_q     <= 1'b0;
      exmem_lw_q     <= 1'b0;
      exmem_sw_q     <= 1'b0;
      exmem_dst_q    <= '0;
      exmem_alu_q    <= '0;
      exmem_sd_q     <= '0;
      memwb_vld_q    <= 1'b0;
      memwb_wr_q     <= 1'b0;
      memwb_dst_q    <= '0;
      memwb_res_q    <= '0;
      retire_valid_q <= 1'b0;
      retire_count_q <= '0;
      stall_count_q  <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_W'(i);
    end else if (run) begin
      pc_q           <= pc_d;
      ifid_vld_q     <= ifid_vld_d;
      ifid_ir_q      <= ifid_ir_d;
      ifid_pc_q      <= ifid_pc_d;
      idex_vld_q     <= idex_vld_d;
      idex_ir_q      <= idex_ir_d;
      idex_pc_q      <= idex_pc_d;
      idex_a_q       <= idex_a_d;
      idex_b_q       <= idex_b_d;
      stall_count_q  <= stall_count_d;
      exmem_vld_q    <= idex_vld_q;
      exmem_wr_q     <= ex_wr;
      exmem_lw_q     <= idex_vld_q && ex_lw;
      exmem_sw_q     <= idex_vld_q && ex_sw;
      exmem_dst_q    <= ex_dst;
      exmem_alu_q    <= ex_res;
      exmem_sd_q     <= ex_b;
      memwb_vld_q    <= exmem_vld_q;
      memwb_wr_q     <= exmem_wr_q;
      memwb_dst_q    <= exmem_dst_q;
      memwb_res_q    <= mem_res;
      // WB: memwb_wr_q already excludes r0 and bubbles
      if (memwb_wr_q) regs_q[memwb_dst_q] <= memwb_res_q;
      retire_valid_q <= memwb_vld_q;
      retire_count_q <= retire_count_q + 32'(memwb_vld_q);
    end else begin
      retire_valid_q <= 1'b0;
    end
  end

  assign dbg_rdata    = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];
  assign pc           = pc_q;
  assign retire_valid = retire_valid_q;
  assign retire_count = retire_count_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipe5_cpu_fwd.sv
// Directed-program bench for pipe5_cpu_fwd: expected register contents are queued
// as each program is built and popped against the debug read port once it drains.
module tb_pipe5_cpu_fwd;
  localparam int DATA_W     = 32;
  localparam int NREG       = 32;
  localparam int IMEM_DEPTH = 64;
  localparam int DMEM_DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b1;
  logic        imem_we = 1'b0;
  logic [5:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata, pc, retire_count, stall_count;
  logic        retire_valid;

  pipe5_cpu_fwd #(.DATA_W(DATA_W), .NREG(NREG), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .pc(pc), .retire_valid(retire_valid),
    .retire_count(retire_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct { int r; logic [31:0] v; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] prog [IMEM_DEPTH];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] add_i(input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'd32};
  endfunction
  function automatic logic [31:0] sub_i(input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'd34};
  endfunction
  function automatic logic [31:0] imm_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < IMEM_DEPTH; i++) prog[i] = NOP;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Holds reset while the program is written, then releases it between edges.
  task automatic load_and_start();
    reset_n = 1'b0;
    run     = 1'b1;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = prog[i];
      @(posedge clock); #1;
    end
    imem_we = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic rd_reg(input int r, output logic [31:0] v);
    dbg_raddr = 5'(r);
    #1;
    v = dbg_rdata;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] v;
    clear_prog();
    prog[0] = add_i(3, 1, 2);
    exp_q.push_back('{7, 32'd7});
    exp_q.push_back('{31, 32'd31});
    exp_q.push_back('{0, 32'd0});
    load_and_start();
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %0h exp 0", pc); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %0b exp 0", retire_valid); end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL reset_rc got %0d exp 0", retire_count); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_sc got %0d exp 0", stall_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); rd_reg(e.r, v); checks++;
      if (v !== e.v) begin errors++; $display("FAIL reset_r%0d got %0h exp %0h", e.r, v, e.v); end
    end
  endtask

  task automatic test_forwarding();
    exp_t e; logic [31:0] v;
    clear_prog();
    prog[0] = add_i(3, 1, 2);
    prog[1] = sub_i(4, 3, 1);
    prog[2] = add_i(5, 4, 3);
    prog[5] = add_i(13, 5, 1);
    exp_q.push_back('{3, 32'd3});
    exp_q.push_back('{4, 32'd2});
    exp_q.push_back('{5, 32'd5});
    exp_q.push_back('{13, 32'd6});
    load_and_start();
    step(4);
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL fwd_rv4 got %0b exp 0", retire_valid); end
    step(1);
    checks++; if (retire_valid !== 1'b1) begin errors++; $display("FAIL fwd_rv5 got %0b exp 1", retire_valid); end
    step(2);
    checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL fwd_rc7 got %0d exp 3", retire_count); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (retire_valid !== 1'b1) begin errors++; $display("FAIL b2b_rv got %0b exp 1", retire_valid); end
    end
    step(5);
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL fwd_sc got %0d exp 0", stall_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); rd_reg(e.r, v); checks++;
      if (v !== e.v) begin errors++; $display("FAIL fwd_r%0d got %0h exp %0h", e.r, v, e.v); end
    end
  endtask

  task automatic test_load_use();
    exp_t e; logic [31:0] v;
    clear_prog();
    prog[0] = imm_i(6'd43, 0, 5, 8);
    prog[1] = imm_i(6'd35, 0, 6, 8);
    prog[2] = add_i(7, 6, 1);
    exp_q.push_back('{6, 32'd5});
    exp_q.push_back('{7, 32'd6});
    load_and_start();
    step(3);
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL lu_sc3 got %0d exp 0", stall_count); end
    step(1);
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_sc4 got %0d exp 1", stall_count); end
    step(3);
    checks++; if (retire_count !== 32'd2) begin errors++; $display("FAIL lu_rc7 got %0d exp 2", retire_count); end
    step(1);
    checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL lu_rc8 got %0d exp 3", retire_count); end
    step(6);
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_sc_end got %0d exp 1", stall_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); rd_reg(e.r, v); checks++;
      if (v !== e.v) begin errors++; $display("FAIL lu_r%0d got %0h exp %0h", e.r, v, e.v); end
    end
  endtask

  task automatic test_branch_taken();
    exp_t e; logic [31:0] v;
    clear_prog();
    prog[0] = imm_i(6'd4, 1, 1, 2);
    prog[1] = add_i(8, 1, 1);
    prog[2] = add_i(9, 1, 1);
    prog[3] = add_i(10, 1, 2);
    exp_q.push_back('{8, 32'd8});
    exp_q.push_back('{9, 32'd9});
    exp_q.push_back('{10, 32'd3});
    load_and_start();
    step(7);
    checks++; if (retire_count !== 32'd1) begin errors++; $display("FAIL beq_rc7 got %0d exp 1", retire_count); end
    step(1);
    checks++; if (retire_count !== 32'd2) begin errors++; $display("FAIL beq_rc8 got %0d exp 2", retire_count); end
    step(6);
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL beq_sc got %0d exp 0", stall_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); rd_reg(e.r, v); checks++;
      if (v !== e.v) begin errors++; $display("FAIL beq_r%0d got %0h exp %0h", e.r, v, e.v); end
    end
  endtask

  task automatic test_branch_untaken();
    exp_t e; logic [31:0] v;
    clear_prog();
    prog[0] = imm_i(6'd4, 1, 2, 2);
    prog[1] = add_i(8, 1, 2);
    prog[2] = add_i(9, 2, 2);
    prog[3] = add_i(10, 1, 1);
    exp_q.push_back('{8, 32'd3});
    exp_q.push_back('{9, 32'd4});
    exp_q.push_back('{10, 32'd2});
    load_and_start();
    step(7);
    checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL bne_rc7 got %0d exp 3", retire_count); end
    step(1);
    checks++; if (retire_count !== 32'd4) begin errors++; $display("FAIL bne_rc8 got %0d exp 4", retire_count); end
    step(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); rd_reg(e.r, v); checks++;
      if (v !== e.v) begin errors++; $display("FAIL bne_r%0d got %0h exp %0h", e.r, v, e.v); end
    end
  endtask

  task automatic test_r0();
    exp_t e; logic [31:0] v;
    clear_prog();
    prog[0] = add_i(0, 1, 2);
    prog[1] = add_i(11, 0, 0);
    prog[3] = add_i(14, 0, 1);
    exp_q.push_back('{11, 32'd0});
    exp_q.push_back('{14, 32'd1});
    exp_q.push_back('{0, 32'd0});
    load_and_start();
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); rd_reg(e.r, v); checks++;
      if (v !== e.v) begin errors++; $display("FAIL r0_r%0d got %0h exp %0h", e.r, v, e.v); end
    end
  endtask

  task automatic test_run_halt();
    exp_t e; logic [31:0] v, pc_s, rc_s;
    clear_prog();
    prog[0] = add_i(3, 1, 2);
    prog[1] = add_i(4, 3, 3);
    prog[2] = add_i(5, 4, 1);
    exp_q.push_back('{3, 32'd3});
    exp_q.push_back('{4, 32'd6});
    exp_q.push_back('{5, 32'd7});
    load_and_start();
    step(6);
    checks++; if (retire_count !== 32'd2) begin errors++; $display("FAIL halt_rc6 got %0d exp 2", retire_count); end
    pc_s = pc; rc_s = retire_count;
    run = 1'b0;
    step(1);
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL halt_rv got %0b exp 0", retire_valid); end
    step(4);
    checks++; if (pc !== pc_s) begin errors++; $display("FAIL halt_pc got %0h exp %0h", pc, pc_s); end
    checks++; if (retire_count !== rc_s) begin errors++; $display("FAIL halt_rc got %0d exp %0d", retire_count, rc_s); end
    run = 1'b1;
    step(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); rd_reg(e.r, v); checks++;
      if (v !== e.v) begin errors++; $display("FAIL halt_r%0d got %0h exp %0h", e.r, v, e.v); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [31:0] v;
    clear_prog();
    prog[0] = add_i(3, 1, 1);
    prog[5] = imm_i(6'd43, 0, 9, 8);
    load_and_start();
    step(7);
    rd_reg(3, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL rmid_pre_r3 got %0h exp 2", v); end
    reset_n = 1'b0;
    #1;
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL rmid_pc got %0h exp 0", pc); end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL rmid_rc got %0d exp 0", retire_count); end
    rd_reg(3, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL rmid_r3 got %0h exp 3", v); end
    clear_prog();
    prog[0] = imm_i(6'd35, 0, 12, 8);
    exp_q.push_back('{12, 32'd5});
    load_and_start();
    step(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); rd_reg(e.r, v); checks++;
      if (v !== e.v) begin errors++; $display("FAIL rmid_r%0d got %0h exp %0h", e.r, v, e.v); end
    end
  endtask

  task automatic test_pc_wrap();
    clear_prog();
    load_and_start();
    step(IMEM_DEPTH - 1);
    checks++; if (pc !== 32'(4 * (IMEM_DEPTH - 1))) begin errors++; $display("FAIL wrap_last got %0h exp %0h", pc, 4 * (IMEM_DEPTH - 1)); end
    step(1);
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL wrap_zero got %0h exp 0", pc); end
    step(1);
    checks++; if (pc !== 32'd4) begin errors++; $display("FAIL wrap_next got %0h exp 4", pc); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_taken();
    test_branch_untaken();
    test_r0();
    test_run_halt();
    test_reset_mid();
    test_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
